// File: rtl/pc_pkg.sv
// Shared types and constants for the fetch-stage PC generator.
// The alignment mask helper clears the low log2(insn_bytes) bits of a target.
package pc_pkg;

  typedef enum logic [1:0] {
    S_BOOT,
    S_RUN,
    S_PEND
  } pc_state_e;

  localparam logic [31:0] DEF_RESET_VEC = 32'h0040_0000;
  localparam logic [31:0] DEF_EXC_VEC   = 32'h0040_0004;

  function automatic logic [63:0] align_mask(input int unsigned insn_bytes);
    align_mask = ~(64'(insn_bytes) - 64'd1);
  endfunction

endpackage

// File: rtl/pc_redirect_buf.sv
// Pending-redirect buffer: captures a redirect/exception target while the pipeline is held.
// An exception always overwrites; a redirect overwrites only a pending redirect, never a pending exception.
module pc_redirect_buf #(
  parameter int PC_W = 32
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            capture_i,
  input  logic            clear_i,
  input  logic            exc_i,
  input  logic            redir_i,
  input  logic [PC_W-1:0] tgt_i,
  output logic            accept_o,
  output logic            pend_is_exc_o,
  output logic [PC_W-1:0] pend_pc_o
);

  logic            pendValid_q;
  logic            pendIsExc_q;
  logic [PC_W-1:0] pendPc_q;

  assign accept_o      = capture_i & (~pendValid_q | exc_i | (redir_i & ~pendIsExc_q));
  assign pend_is_exc_o = pendIsExc_q;
  assign pend_pc_o     = pendPc_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pendValid_q <= 1'b0;
      pendIsExc_q <= 1'b0;
      pendPc_q    <= '0;
    end else if (clear_i) begin
      pendValid_q <= 1'b0;
      pendIsExc_q <= 1'b0;
    end else if (accept_o) begin
      pendValid_q <= 1'b1;
      pendIsExc_q <= exc_i;
      pendPc_q    <= tgt_i;
    end
  end

endmodule

// File: rtl/pc_gen.sv
// Fetch-stage program-counter generator with prioritised redirect/exception handling.
// Optional performance counters (fetch_cnt, redir_cnt) are built when PC_GEN_PERF_EN is defined.
module pc_gen
  import pc_pkg::*;
#(
  parameter int              PC_W       = 32,
  parameter logic [PC_W-1:0] RESET_VEC  = PC_W'(DEF_RESET_VEC),
  parameter logic [PC_W-1:0] EXC_VEC    = PC_W'(DEF_EXC_VEC),
  parameter int              INSN_BYTES = 4
) (
  input  logic            clock,
  input  logic            reset_n,
  input  logic            enable,
  input  logic            stall_signal,
  input  logic            fetch_ready,
  input  logic            redirect_valid,
  input  logic [PC_W-1:0] redirect_pc,
  input  logic            exc_valid,
  output logic [PC_W-1:0] current_pc,
  output logic            fetch_valid,
  output logic [PC_W-1:0] fetch_pc,
  output logic            redirect_taken,
  output logic            align_err
`ifdef PC_GEN_PERF_EN
  ,
  output logic [31:0]     fetch_cnt,
  output logic [31:0]     redir_cnt
`endif
);

  localparam logic [PC_W-1:0] ALIGN_MASK = PC_W'(align_mask(INSN_BYTES));
  localparam logic [PC_W-1:0] PC_INC     = PC_W'(INSN_BYTES);

  pc_state_e       state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic            redirTaken_q, redirTaken_d;
  logic            alignErr_q, alignErr_d;

  logic            upd, req, misaligned, capture, clearPend, bufAccept, pendIsExc;
  logic [PC_W-1:0] redirAligned, tgt, pendPc;

  assign upd          = enable & ~stall_signal;
  assign req          = exc_valid | redirect_valid;
  assign redirAligned = redirect_pc & ALIGN_MASK;
  assign misaligned   = |(redirect_pc & ~ALIGN_MASK);
  assign tgt          = exc_valid ? EXC_VEC : redirAligned;
  // Requests are buffered only while stalled; enable=0 ignores them entirely.
  assign capture      = enable & stall_signal & req & (state_q != S_BOOT);
  assign clearPend    = (state_q == S_PEND) & upd;

  pc_redirect_buf #(
    .PC_W(PC_W)
  ) u_redirect_buf (
    .clk_i        (clock),
    .rst_ni       (reset_n),
    .capture_i    (capture),
    .clear_i      (clearPend),
    .exc_i        (exc_valid),
    .redir_i      (redirect_valid),
    .tgt_i        (tgt),
    .accept_o     (bufAccept),
    .pend_is_exc_o(pendIsExc),
    .pend_pc_o    (pendPc)
  );

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    redirTaken_d = 1'b0;
    alignErr_d   = 1'b0;
    fetch_valid  = 1'b0;
    unique case (state_q)
      S_BOOT: state_d = S_RUN;
      S_RUN: begin
        fetch_valid = upd;
        if (upd && req) begin
          pc_d         = tgt;
          redirTaken_d = 1'b1;
          alignErr_d   = ~exc_valid & misaligned;
        end else if (upd && fetch_ready) begin
          pc_d = pc_q + PC_INC;
        end else if (capture) begin
          state_d    = S_PEND;
          alignErr_d = ~exc_valid & misaligned;
        end
      end
      S_PEND: begin
        if (upd) begin
          // Same-cycle exception beats same-cycle redirect, which beats the buffered target.
          if (exc_valid) begin
            pc_d = EXC_VEC;
          end else if (redirect_valid && !pendIsExc) begin
            pc_d       = redirAligned;
            alignErr_d = misaligned;
          end else begin
            pc_d = pendPc;
          end
          redirTaken_d = 1'b1;
          state_d      = S_RUN;
        end else if (capture) begin
          alignErr_d = bufAccept & ~exc_valid & misaligned;
        end
      end
      default: state_d = S_BOOT;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= S_BOOT;
      pc_q         <= RESET_VEC;
      redirTaken_q <= 1'b0;
      alignErr_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      redirTaken_q <= redirTaken_d;
      alignErr_q   <= alignErr_d;
    end
  end

  assign current_pc     = pc_q;
  assign fetch_pc       = pc_q;
  assign redirect_taken = redirTaken_q;
  assign align_err      = alignErr_q;

`ifdef PC_GEN_PERF_EN
  logic [31:0] fetchCnt_q, redirCnt_q;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      fetchCnt_q <= '0;
      redirCnt_q <= '0;
    end else begin
      if (fetch_valid && fetch_ready) fetchCnt_q <= fetchCnt_q + 32'd1;
      if (redirTaken_q) redirCnt_q <= redirCnt_q + 32'd1;
    end
  end

  assign fetch_cnt = fetchCnt_q;
  assign redir_cnt = redirCnt_q;
`endif

endmodule

// File: tb/tb_pc_gen.sv
// Self-checking bench for pc_gen: table of per-cycle vectors plus a reset-while-pending sequence.
// When PC_GEN_PERF_EN is defined the fetch counter is also checked across an enable freeze.
module tb_pc_gen;

  localparam logic [31:0] RV = 32'h0040_0000;
  localparam logic [31:0] EV = 32'h0040_0004;

  logic        clock, reset_n, enable, stall_signal, fetch_ready;
  logic        redirect_valid, exc_valid;
  logic [31:0] redirect_pc;
  logic [31:0] current_pc, fetch_pc;
  logic        fetch_valid, redirect_taken, align_err;
`ifdef PC_GEN_PERF_EN
  logic [31:0] fetch_cnt, redir_cnt;
  logic [31:0] cntSnap;
`endif

  pc_gen dut (
    .clock         (clock),
    .reset_n       (reset_n),
    .enable        (enable),
    .stall_signal  (stall_signal),
    .fetch_ready   (fetch_ready),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .exc_valid     (exc_valid),
    .current_pc    (current_pc),
    .fetch_valid   (fetch_valid),
    .fetch_pc      (fetch_pc),
    .redirect_taken(redirect_taken),
    .align_err     (align_err)
`ifdef PC_GEN_PERF_EN
    ,
    .fetch_cnt     (fetch_cnt),
    .redir_cnt     (redir_cnt)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic        en, st, rdy, rv;
    logic [31:0] rpc;
    logic        ev;
    logic        fv;
    logic [31:0] pc;
    logic        rt, ae;
  } vec_t;

  typedef struct {
    logic [31:0] pc;
    logic        rt, ae;
  } exp_t;

  vec_t        vecs[25];
  exp_t        sb[$];
  int          total  = 0;
  int          passed = 0;
  logic [31:0] expPc;

  function automatic vec_t mk(logic en, logic st, logic rdy, logic rv, logic [31:0] rpc,
                              logic ev, logic fv, logic [31:0] pc, logic rt, logic ae);
    vec_t v;
    v.en = en; v.st = st; v.rdy = rdy; v.rv = rv; v.rpc = rpc; v.ev = ev;
    v.fv = fv; v.pc = pc; v.rt = rt; v.ae = ae;
    return v;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
  endtask

  // Drives one cycle's inputs at the negedge, checks the combinational view before the edge
  // and the registered results after it, then returns at the following negedge.
  task automatic applyStimulus(input vec_t v);
    exp_t e;
    enable         = v.en;
    stall_signal   = v.st;
    fetch_ready    = v.rdy;
    redirect_valid = v.rv;
    redirect_pc    = v.rpc;
    exc_valid      = v.ev;
    e.pc = v.pc; e.rt = v.rt; e.ae = v.ae;
    sb.push_back(e);
    #1;
    checkOutput("fetch_valid", {31'd0, fetch_valid}, {31'd0, v.fv});
    checkOutput("fetch_pc", fetch_pc, expPc);
    @(posedge clock);
    #1;
    e = sb.pop_front();
    checkOutput("current_pc", current_pc, e.pc);
    checkOutput("redirect_taken", {31'd0, redirect_taken}, {31'd0, e.rt});
    checkOutput("align_err", {31'd0, align_err}, {31'd0, e.ae});
    expPc = e.pc;
    @(negedge clock);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    //              en st rdy rv rpc           ev fv pc            rt ae
    vecs[0]  = mk(1, 0, 1, 0, 32'h0,        0, 0, 32'h00400000, 0, 0);
    vecs[1]  = mk(1, 0, 1, 0, 32'h0,        0, 1, 32'h00400004, 0, 0);
    vecs[2]  = mk(1, 0, 1, 0, 32'h0,        0, 1, 32'h00400008, 0, 0);
    vecs[3]  = mk(1, 0, 1, 0, 32'h0,        0, 1, 32'h0040000C, 0, 0);
    vecs[4]  = mk(1, 0, 1, 1, 32'h00400100, 0, 1, 32'h00400100, 1, 0);
    vecs[5]  = mk(1, 0, 0, 0, 32'h0,        0, 1, 32'h00400100, 0, 0);
    vecs[6]  = mk(1, 1, 1, 1, 32'h00400200, 0, 0, 32'h00400100, 0, 0);
    vecs[7]  = mk(1, 1, 1, 0, 32'h0,        1, 0, 32'h00400100, 0, 0);
    vecs[8]  = mk(1, 1, 1, 1, 32'h00400300, 0, 0, 32'h00400100, 0, 0);
    vecs[9]  = mk(1, 0, 1, 0, 32'h0,        0, 0, EV,           1, 0);
    vecs[10] = mk(1, 0, 0, 0, 32'h0,        0, 1, EV,           0, 0);
    vecs[11] = mk(1, 0, 0, 1, 32'h00400102, 0, 1, 32'h00400100, 1, 1);
    vecs[12] = mk(1, 0, 0, 1, 32'h00400103, 1, 1, EV,           1, 0);
    vecs[13] = mk(1, 0, 0, 0, 32'h0,        0, 1, EV,           0, 0);
    vecs[14] = mk(1, 1, 1, 1, 32'h00400206, 0, 0, EV,           0, 1);
    vecs[15] = mk(1, 1, 1, 1, 32'h00400300, 0, 0, EV,           0, 0);
    vecs[16] = mk(1, 0, 1, 1, 32'h00400400, 0, 0, 32'h00400400, 1, 0);
    vecs[17] = mk(0, 0, 1, 0, 32'h0,        0, 0, 32'h00400400, 0, 0);
    vecs[18] = mk(0, 0, 1, 0, 32'h0,        0, 0, 32'h00400400, 0, 0);
    vecs[19] = mk(0, 0, 1, 0, 32'h0,        0, 0, 32'h00400400, 0, 0);
    vecs[20] = mk(1, 0, 1, 0, 32'h0,        0, 1, 32'h00400404, 0, 0);
    vecs[21] = mk(1, 0, 0, 1, 32'hFFFFFFFC, 0, 1, 32'hFFFFFFFC, 1, 0);
    vecs[22] = mk(1, 0, 1, 0, 32'h0,        0, 1, 32'h00000000, 0, 0);
    vecs[23] = mk(1, 0, 1, 0, 32'h0,        0, 1, 32'h00000004, 0, 0);
    vecs[24] = mk(1, 1, 1, 0, 32'h0,        0, 0, 32'h00000004, 0, 0);

    reset_n        = 1'b0;
    enable         = 1'b0;
    stall_signal   = 1'b0;
    fetch_ready    = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    exc_valid      = 1'b0;
    repeat (2) @(negedge clock);
    checkOutput("reset current_pc", current_pc, RV);
    checkOutput("reset fetch_valid", {31'd0, fetch_valid}, 32'd0);
    checkOutput("reset redirect_taken", {31'd0, redirect_taken}, 32'd0);
    checkOutput("reset align_err", {31'd0, align_err}, 32'd0);
    reset_n = 1'b1;
    expPc   = RV;

    for (int i = 0; i < 25; i++) begin
`ifdef PC_GEN_PERF_EN
      if (i == 17) cntSnap = fetch_cnt;
`endif
      applyStimulus(vecs[i]);
`ifdef PC_GEN_PERF_EN
      if (i == 19) checkOutput("fetch_cnt frozen", fetch_cnt, cntSnap);
`endif
    end

    // Park a redirect in the pending buffer, then reset asynchronously mid-cycle.
    applyStimulus(mk(1, 1, 1, 1, 32'h00400500, 0, 0, 32'h00000004, 0, 0));
    stall_signal   = 1'b0;
    redirect_valid = 1'b0;
    #2;
    reset_n = 1'b0;
    #1;
    checkOutput("async reset current_pc", current_pc, RV);
    checkOutput("async reset fetch_valid", {31'd0, fetch_valid}, 32'd0);
    checkOutput("async reset redirect_taken", {31'd0, redirect_taken}, 32'd0);
    @(negedge clock);
    reset_n = 1'b1;
    expPc   = RV;
    applyStimulus(mk(1, 0, 1, 0, 32'h0, 0, 0, RV, 0, 0));
    applyStimulus(mk(1, 0, 1, 0, 32'h0, 0, 1, 32'h00400004, 0, 0));
    applyStimulus(mk(1, 0, 1, 0, 32'h0, 0, 1, 32'h00400008, 0, 0));

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
